// File: rtl/mem_write_monitor_pkg.sv
// mem_write_monitor_pkg
//   Shared types for the data-memory write monitor: FSM state encoding,
//   signature table entry and trace FIFO entry. Entry fields are sized for
//   the widest supported bus (64 bits); narrower buses are zero-extended.
package mem_write_monitor_pkg;

  localparam int MWM_ADDR_MAX = 64;
  localparam int MWM_DATA_MAX = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    TMO  = 2'd3
  } mwm_state_e;

  typedef struct packed {
    logic                    en;
    logic [MWM_ADDR_MAX-1:0] addr;
    logic [MWM_DATA_MAX-1:0] data;
  } sig_entry_t;

  typedef struct packed {
    logic [MWM_ADDR_MAX-1:0] addr;
    logic [MWM_DATA_MAX-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/mem_write_monitor_if.sv
// mem_write_monitor_if
//   Core data-memory write port as seen by the monitor.
//   memwrite  : write strobes, any set bit marks a write
//   dataadr   : write address
//   writedata : write data
//   master = core side (drives), slave = monitor side (observes).
interface mem_write_monitor_if #(
  parameter int AW   = 64,
  parameter int DW   = 64,
  parameter int WE_W = 2
);
  logic [WE_W-1:0] memwrite;
  logic [AW-1:0]   dataadr;
  logic [DW-1:0]   writedata;

  modport master (output memwrite, output dataadr, output writedata);
  modport slave  (input  memwrite, input  dataadr, input  writedata);
endinterface

// File: rtl/mwm_trace_fifo.sv
// mwm_trace_fifo
//   Synchronous show-ahead FIFO for write trace entries. Used by
//   mem_write_monitor only when WR_TRACE_EN is defined.
//   clk, reset(sync, active-low), clr : clock / reset / flush
//   push, din   : enqueue request and entry; dropped when full unless a pop
//                 happens in the same cycle
//   pop         : remove head (ignored when empty)
//   valid, head : non-empty flag and head entry
//   ovf         : sticky, set when a push was dropped; cleared by reset/clr
module mwm_trace_fifo
  import mem_write_monitor_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  trace_entry_t din,
  output logic         valid,
  output trace_entry_t head,
  output logic         ovf
);

  localparam int            PW      = $clog2(DEPTH);
  localparam logic [PW:0]   PTR_ONE = 1;

  trace_entry_t mem [DEPTH];
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  logic         empty;
  logic         full;
  logic         do_pop;
  logic         do_push;

  // Extra pointer MSB distinguishes full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);

  assign valid = !empty;
  assign head  = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !do_push)
        ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/mem_write_monitor.sv
// mem_write_monitor
//   Watches the core's data-memory write port. A run starts on a start
//   pulse and ends with PASS when an enabled (address,data) signature is
//   written, or TIMEOUT when the cycle limit expires. Optional write trace
//   FIFO is built when the macro WR_TRACE_EN is defined; otherwise the
//   trace outputs are tied to 0.
//   clk, reset          : clock, synchronous active-low reset
//   start               : 1-cycle pulse, (re)starts a run from any state
//   cfg_we/idx/en/addr/data : signature table write port (ignored in RUN)
//   wr_bus              : core write port (memwrite/dataadr/writedata)
//   timeout_cycles      : run limit in cycles, 0 disables timeout
//   busy/done/pass/timeout : run status
//   hit_idx, hit_cycle  : matching entry and cycle of the hit
//   cycle_cnt, wr_count : run cycles and write events (saturating)
//   trace_pop/valid/addr/data/ovf : trace FIFO access
//
// state | meaning
// IDLE  | after reset, waiting for the first start
// RUN   | run in progress, counting cycles and writes
// PASS  | run ended on a signature hit, results held
// TMO   | run ended on timeout, results held
module mem_write_monitor
  import mem_write_monitor_pkg::*;
#(
  parameter int AW          = 64,
  parameter int DW          = 64,
  parameter int WE_W        = 2,
  parameter int N_CHK       = 8,
  parameter int CW          = 32,
  parameter int TRACE_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     cfg_we,
  input  logic [$clog2(N_CHK)-1:0] cfg_idx,
  input  logic                     cfg_en,
  input  logic [AW-1:0]            cfg_addr,
  input  logic [DW-1:0]            cfg_data,
  mem_write_monitor_if.slave       wr_bus,
  input  logic [CW-1:0]            timeout_cycles,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout,
  output logic [$clog2(N_CHK)-1:0] hit_idx,
  output logic [CW-1:0]            hit_cycle,
  output logic [CW-1:0]            cycle_cnt,
  output logic [CW-1:0]            wr_count,
  input  logic                     trace_pop,
  output logic                     trace_valid,
  output logic [AW-1:0]            trace_addr,
  output logic [DW-1:0]            trace_data,
  output logic                     trace_ovf
);

  localparam int IW = $clog2(N_CHK);

  mwm_state_e      state_q;
  mwm_state_e      state_d;
  sig_entry_t      sig_tbl [N_CHK];
  logic [WE_W-1:0] wr_strobe;
  logic            wr_ev;
  logic            hit_c;
  logic [IW-1:0]   hit_idx_c;
  logic            tmo_c;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  assign wr_strobe = wr_bus.memwrite;
  assign wr_ev     = (state_q == RUN) && (|wr_strobe);

  // Priority encoder: scanning downwards leaves the lowest matching index.
  always_comb begin
    hit_c     = 1'b0;
    hit_idx_c = '0;
    for (int i = N_CHK - 1; i >= 0; i--) begin
      if (wr_ev && sig_tbl[i].en &&
          sig_tbl[i].addr == MWM_ADDR_MAX'(wr_bus.dataadr) &&
          sig_tbl[i].data == MWM_DATA_MAX'(wr_bus.writedata)) begin
        hit_c     = 1'b1;
        hit_idx_c = IW'(i);
      end
    end
  end

  assign tmo_c = (timeout_cycles != '0) && (cycle_cnt == timeout_cycles - CW'(1));

  always_ff @(posedge clk) begin
    if (!reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          // Hit takes precedence over a timeout in the same cycle.
          if (hit_c)
            state_d = PASS;
          else if (tmo_c)
            state_d = TMO;
        end
        default: state_d = state_q;
      endcase
    end
  end

  assign busy    = (state_q == RUN);
  assign pass    = (state_q == PASS);
  assign timeout = (state_q == TMO);
  assign done    = pass || timeout;

  always_ff @(posedge clk) begin
    if (!reset || start) begin
      cycle_cnt <= '0;
      wr_count  <= '0;
      hit_idx   <= '0;
      hit_cycle <= '0;
    end else if (state_q == RUN) begin
      if (wr_ev)
        wr_count <= sat_inc(wr_count);
      // Counter freezes on the exit edge so it shows the last RUN cycle.
      if (state_d == RUN)
        cycle_cnt <= sat_inc(cycle_cnt);
      if (hit_c) begin
        hit_idx   <= hit_idx_c;
        hit_cycle <= cycle_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N_CHK; i++)
        sig_tbl[i] <= '0;
    end else if (cfg_we && state_q != RUN) begin
      sig_tbl[cfg_idx] <= '{en:   cfg_en,
                            addr: MWM_ADDR_MAX'(cfg_addr),
                            data: MWM_DATA_MAX'(cfg_data)};
    end
  end

`ifdef WR_TRACE_EN
  trace_entry_t tr_din;
  trace_entry_t tr_head;

  assign tr_din = '{addr: MWM_ADDR_MAX'(wr_bus.dataadr),
                    data: MWM_DATA_MAX'(wr_bus.writedata)};

  // start flushes the FIFO, so a write in that cycle is not recorded.
  mwm_trace_fifo #(
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (start),
    .push  (wr_ev && !start),
    .pop   (trace_pop),
    .din   (tr_din),
    .valid (trace_valid),
    .head  (tr_head),
    .ovf   (trace_ovf)
  );

  assign trace_addr = tr_head.addr[AW-1:0];
  assign trace_data = tr_head.data[DW-1:0];
`else
  localparam int unused_trace_depth = TRACE_DEPTH;
  logic unused_trace_pop;

  assign unused_trace_pop = trace_pop;
  assign trace_valid      = 1'b0;
  assign trace_addr       = '0;
  assign trace_data       = '0;
  assign trace_ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_write_monitor.sv
module tb_mem_write_monitor;

  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int WE_W  = 2;
  localparam int N_CHK = 8;
  localparam int CW    = 32;
  localparam int TD    = 4;
  localparam int IW    = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            cfg_we = 1'b0;
  logic [IW-1:0]   cfg_idx = '0;
  logic            cfg_en = 1'b0;
  logic [AW-1:0]   cfg_addr = '0;
  logic [DW-1:0]   cfg_data = '0;
  logic [CW-1:0]   timeout_cycles = '0;
  logic            trace_pop = 1'b0;
  logic            busy, done, pass, timeout, trace_valid, trace_ovf;
  logic [IW-1:0]   hit_idx;
  logic [CW-1:0]   hit_cycle, cycle_cnt, wr_count;
  logic [AW-1:0]   trace_addr;
  logic [DW-1:0]   trace_data;

  always #5 clk = ~clk;

  mem_write_monitor_if #(.AW(AW), .DW(DW), .WE_W(WE_W)) wr_if ();

  mem_write_monitor #(
    .AW(AW), .DW(DW), .WE_W(WE_W), .N_CHK(N_CHK), .CW(CW), .TRACE_DEPTH(TD)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .wr_bus(wr_if),
    .timeout_cycles(timeout_cycles),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .hit_idx(hit_idx), .hit_cycle(hit_cycle),
    .cycle_cnt(cycle_cnt), .wr_count(wr_count),
    .trace_pop(trace_pop), .trace_valid(trace_valid),
    .trace_addr(trace_addr), .trace_data(trace_data), .trace_ovf(trace_ovf)
  );

  typedef struct {
    logic          pass_v;
    logic          tmo_v;
    logic [IW-1:0] idx;
    logic [CW-1:0] hcyc;
    logic [CW-1:0] ccnt;
    logic [CW-1:0] wcnt;
  } run_exp_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } tr_exp_t;

  run_exp_t exp_run[$];
  tr_exp_t  exp_tr[$];
  run_exp_t mon_r;
  tr_exp_t  mon_t;
  int       n_chk = 0;
  int       n_pass = 0;
  logic     done_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Monitor: compare a run result when done rises, a trace entry when popped.
  always @(negedge clk) begin
    if (done === 1'b1 && done_prev !== 1'b1) begin
      if (exp_run.size() == 0) begin
        chk("unexpected_run_end", 64'(done), 64'd0);
      end else begin
        mon_r = exp_run.pop_front();
        chk("run_pass",      64'(pass),      64'(mon_r.pass_v));
        chk("run_timeout",   64'(timeout),   64'(mon_r.tmo_v));
        chk("run_hit_idx",   64'(hit_idx),   64'(mon_r.idx));
        chk("run_hit_cycle", 64'(hit_cycle), 64'(mon_r.hcyc));
        chk("run_cycle_cnt", 64'(cycle_cnt), 64'(mon_r.ccnt));
        chk("run_wr_count",  64'(wr_count),  64'(mon_r.wcnt));
      end
    end
    done_prev = done;
    if (trace_valid === 1'b1 && trace_pop === 1'b1) begin
      if (exp_tr.size() == 0) begin
        chk("unexpected_trace_entry", 64'(trace_valid), 64'd0);
      end else begin
        mon_t = exp_tr.pop_front();
        chk("trace_addr", 64'(trace_addr), 64'(mon_t.a));
        chk("trace_data", 64'(trace_data), 64'(mon_t.d));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic cfg_wr(input int idx, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_en = en; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic wr(input logic [WE_W-1:0] we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic pop);
    wr_if.memwrite = we; wr_if.dataadr = a; wr_if.writedata = d; trace_pop = pop;
    tick();
    wr_if.memwrite = '0; trace_pop = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget && done !== 1'b1; i++)
      tick();
    chk(name, 64'(done), 64'd1);
  endtask

  task automatic push_run(input logic p, input logic t, input int idx, input int hc, input int cc, input int wc);
    run_exp_t e;
    e.pass_v = p; e.tmo_v = t; e.idx = IW'(idx);
    e.hcyc = CW'(hc); e.ccnt = CW'(cc); e.wcnt = CW'(wc);
    exp_run.push_back(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},      64'(busy),        64'd0);
    chk({tag, "_done"},      64'(done),        64'd0);
    chk({tag, "_pass"},      64'(pass),        64'd0);
    chk({tag, "_timeout"},   64'(timeout),     64'd0);
    chk({tag, "_hit_idx"},   64'(hit_idx),     64'd0);
    chk({tag, "_hit_cycle"}, 64'(hit_cycle),   64'd0);
    chk({tag, "_cycle_cnt"}, 64'(cycle_cnt),   64'd0);
    chk({tag, "_wr_count"},  64'(wr_count),    64'd0);
    chk({tag, "_tr_valid"},  64'(trace_valid), 64'd0);
    chk({tag, "_tr_ovf"},    64'(trace_ovf),   64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach its end, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tr_exp_t te;
    wr_if.memwrite = '0; wr_if.dataadr = '0; wr_if.writedata = '0;
    idle(3);
    chk_all_zero("reset");
    reset = 1'b1;
    tick();

    // 1: basic pass on cycle 5
    cfg_wr(0, 1'b1, 64'd100, 64'd7);
    cfg_wr(1, 1'b1, 64'd508, 64'd7);
    timeout_cycles = '0;
    start_run();
    chk("t1_busy", 64'(busy), 64'd1);
    push_run(1'b1, 1'b0, 0, 5, 5, 1);
    idle(5);
    wr(2'b01, 64'd100, 64'd7, 1'b0);
    wait_done("t1_done", 5);
    chk("t1_busy_after", 64'(busy), 64'd0);
    wr(2'b01, 64'd100, 64'd7, 1'b0);
    idle(3);
    chk("t1_wr_count_frozen", 64'(wr_count),  64'd1);
    chk("t1_cycle_frozen",    64'(cycle_cnt), 64'd5);

    // 2: timeout after 1000 cycles with non-matching writes
    timeout_cycles = 1000;
    start_run();
    push_run(1'b0, 1'b1, 0, 0, 999, 3);
    wr(2'b01, 64'd100, 64'd8, 1'b0);
    wr(2'b11, 64'd508, 64'd8, 1'b0);
    wr(2'b10, 64'd0,   64'd7, 1'b0);
    chk("t2_busy_mid", 64'(busy), 64'd1);
    chk("t2_done_mid", 64'(done), 64'd0);
    wait_done("t2_done", 1100);

    // 3: two matching entries, lowest enabled index wins
    timeout_cycles = '0;
    cfg_wr(1, 1'b0, 64'd80, 64'd1);
    cfg_wr(2, 1'b1, 64'd80, 64'd1);
    cfg_wr(5, 1'b1, 64'd80, 64'd1);
    start_run();
    push_run(1'b1, 1'b0, 2, 0, 0, 1);
    wr(2'b10, 64'd80, 64'd1, 1'b0);
    wait_done("t3_done", 5);

    // 4: hit on the timeout cycle wins; cfg write during RUN ignored
    timeout_cycles = 10;
    cfg_wr(4, 1'b1, 64'd200, 64'd42);
    start_run();
    push_run(1'b1, 1'b0, 4, 9, 9, 1);
    idle(1);
    cfg_wr(4, 1'b1, 64'd300, 64'd99);
    idle(7);
    wr(2'b10, 64'd200, 64'd42, 1'b0);
    wait_done("t4_done", 5);

    // 5: reset mid-run, then run without reprogramming cannot hit
    timeout_cycles = '0;
    start_run();
    idle(1);
    wr(2'b01, 64'd100, 64'd8, 1'b0);
    idle(1);
    reset = 1'b0;
    tick();
    chk_all_zero("t5_reset");
    reset = 1'b1;
    timeout_cycles = 20;
    start_run();
    push_run(1'b0, 1'b1, 0, 0, 19, 3);
    wr(2'b01, 64'd100, 64'd7,  1'b0);
    wr(2'b10, 64'd80,  64'd1,  1'b0);
    wr(2'b11, 64'd200, 64'd42, 1'b0);
    wait_done("t5_done", 40);

    // 6: trace FIFO overflow, ordering, full+pop, clear on start
    timeout_cycles = '0;
    start_run();
    for (int i = 0; i < 6; i++) begin
`ifdef WR_TRACE_EN
      if (i < TD) begin
        te.a = 64'h1000 + 64'(i);
        te.d = 64'hA0 + 64'(i);
        exp_tr.push_back(te);
      end
`endif
      wr(2'b01, 64'h1000 + 64'(i), 64'hA0 + 64'(i), 1'b0);
    end
    chk("t6_wr_count", 64'(wr_count), 64'd6);
`ifdef WR_TRACE_EN
    chk("t6_ovf_set",   64'(trace_ovf),   64'd1);
    chk("t6_valid_set", 64'(trace_valid), 64'd1);
    te.a = 64'h1006;
    te.d = 64'hA6;
    exp_tr.push_back(te);
    wr(2'b01, 64'h1006, 64'hA6, 1'b1);
    repeat (4) begin
      trace_pop = 1'b1;
      tick();
    end
    trace_pop = 1'b0;
    chk("t6_empty", 64'(trace_valid), 64'd0);
    trace_pop = 1'b1;
    tick();
    trace_pop = 1'b0;
    chk("t6_pop_empty", 64'(trace_valid), 64'd0);
    start_run();
    chk("t6_ovf_cleared", 64'(trace_ovf), 64'd0);
`else
    chk("t6_no_trace_valid", 64'(trace_valid), 64'd0);
    chk("t6_no_trace_ovf",   64'(trace_ovf),   64'd0);
    chk("t6_no_trace_addr",  64'(trace_addr),  64'd0);
`endif

    idle(3);
    chk("run_queue_drained",   64'(exp_run.size()), 64'd0);
    chk("trace_queue_drained", 64'(exp_tr.size()),  64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
